// File: rtl/pipe_pkg.sv
// Shared widths and beat layout for the pipeline stage registers.
package pipe_pkg;

   localparam int PIPE_DATA_W = 128;
   localparam int PIPE_CTRL_W = 16;
   localparam int PIPE_CNT_W  = 16;

   typedef struct packed {
      logic [PIPE_CTRL_W-1:0] ctrl;
      logic [PIPE_DATA_W-1:0] data;
   } pipe_beat_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, bubble masking and stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W               = PIPE_DATA_W,
   parameter int CTRL_W               = PIPE_CTRL_W,
   parameter int CNT_W                = PIPE_CNT_W,
   parameter bit CLEAR_DATA_ON_BUBBLE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Same {ctrl, data} layout as pipe_beat_t, sized by this instance's parameters.
   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } beat_t;

   beat_t main_q;
   beat_t beat_in;
   logic  main_v;
   logic  in_fire;
   logic  out_fire;

   assign beat_in  = '{ctrl: in_ctrl, data: in_data};
   assign in_fire  = in_valid & in_ready;
   assign out_fire = main_v & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   beat_t skid_q;
   logic  skid_v;

   // Registered ready: the stage stops accepting only once the skid entry is occupied.
   assign in_ready = !skid_v;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_q <= '0;
         // NOTE: skid_q payload is left unreset; it is only ever read while skid_v=1.
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else if (skid_v) begin
         if (out_fire) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
         end
      end else if (in_fire) begin
         if (!main_v || out_fire) begin
            main_q <= beat_in;
            main_v <= 1'b1;
         end else begin
            skid_q <= beat_in;
            skid_v <= 1'b1;
         end
      end else if (out_fire) begin
         main_v <= 1'b0;
      end
   end
`else
   assign in_ready = !main_v | out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_v <= 1'b0;
         main_q <= '0;
      end else if (flush) begin
         main_v <= 1'b0;
      end else if (in_fire) begin
         main_q <= beat_in;
         main_v <= 1'b1;
      end else if (out_fire) begin
         main_v <= 1'b0;
      end
   end
`endif

   // Bubbles carry zero control so no downstream write enable can fire.
   assign out_valid = main_v;
   assign out_ctrl  = main_v ? main_q.ctrl : '0;
   assign out_data  = (CLEAR_DATA_ON_BUBBLE && !main_v) ? '0 : main_q.data;

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (main_v & ~out_ready),
      .cnt (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg against a queue-based model.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int DATA_W  = PIPE_DATA_W;
   localparam int CTRL_W  = PIPE_CTRL_W;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [CNT_W-1:0]  stall_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: ordered list of held beats plus the last head payload shown.
   pipe_beat_t        mq[$];
   logic [DATA_W-1:0] m_shown;
   int                m_cnt;
   bit                last_in_fire;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W               (DATA_W),
      .CTRL_W               (CTRL_W),
      .CNT_W                (CNT_W),
      .CLEAR_DATA_ON_BUBBLE (1'b0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .stall_cnt (stall_cnt)
   );

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_in_ready(input bit ordy);
`ifdef PIPE_STAGE_SKID_EN
      return mq.size() < 2;
`else
      return (mq.size() == 0) || ordy;
`endif
   endfunction

   function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [DATA_W-1:0] d);
      return d[CTRL_W-1:0] ^ 16'hA55A;
   endfunction

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic step(input bit iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input bit ordy, input bit fl, input bit r);
      bit         exp_v;
      bit         exp_rdy;
      bit         ofire;
      pipe_beat_t b;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      #1;
      exp_v   = mq.size() != 0;
      exp_rdy = model_in_ready(ordy);
      check("out_valid", out_valid, exp_v);
      check("in_ready", in_ready, exp_rdy);
      check("out_data", out_data, exp_v ? mq[0].data : m_shown);
      check("out_ctrl", out_ctrl, exp_v ? mq[0].ctrl : '0);
      check("stall_cnt", stall_cnt, m_cnt);
      last_in_fire = iv && exp_rdy;
      ofire = exp_v && ordy;
      if (r) begin
         mq.delete();
         m_shown = '0;
         m_cnt   = 0;
      end else begin
         if (exp_v && !ordy && m_cnt < CNT_MAX) m_cnt++;
         if (fl) begin
            mq.delete();
         end else begin
            if (ofire) void'(mq.pop_front());
            if (last_in_fire) begin
               b.data = d;
               b.ctrl = c;
               mq.push_back(b);
            end
         end
         if (mq.size() != 0) m_shown = mq[0].data;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, '0, '0, ordy, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input bit ordy);
      step(1'b1, d, mk_ctrl(d), ordy, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [DATA_W-1:0] vals[3];
      logic [DATA_W-1:0] rd;
      int                idx;

      in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      out_ready = 1'b0; flush = 1'b0; rst = 1'b1;
      mq.delete(); m_shown = '0; m_cnt = 0; last_in_fire = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state.
      idle(1'b0);

      // Streaming 0x1..0x8 with the consumer always ready.
      for (int i = 1; i <= 8; i++) send(DATA_W'(i), 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Reset in the middle of a stalled stream.
      send(DATA_W'(32'h11), 1'b0);
      send(DATA_W'(32'h22), 1'b0);
      idle(1'b0);
      do_reset();
      idle(1'b0);

      // Stall then release: 0xA, 0xB, 0xC in order, no loss or duplication.
      vals[0] = DATA_W'(32'hA); vals[1] = DATA_W'(32'hB); vals[2] = DATA_W'(32'hC);
      idx = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, vals[idx], mk_ctrl(vals[idx]), 1'b0, 1'b0, 1'b0);
         if (last_in_fire) idx++;
      end
      for (int i = 0; i < 10 && (idx < 3 || mq.size() != 0); i++) begin
         if (idx < 3) begin
            step(1'b1, vals[idx], mk_ctrl(vals[idx]), 1'b1, 1'b0, 1'b0);
            if (last_in_fire) idx++;
         end else begin
            idle(1'b1);
         end
      end
      check("stall_drained", DATA_W'(idx), DATA_W'(3));
      idle(1'b1);

      // Flush with beats held and a beat presented in the same cycle.
      send(DATA_W'(32'hA), 1'b0);
      send(DATA_W'(32'hB), 1'b0);
      step(1'b1, DATA_W'(32'hC), mk_ctrl(DATA_W'(32'hC)), 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      send(DATA_W'(32'hD), 1'b1);
      idle(1'b1);
      idle(1'b1);

      // Stall counter saturation.
      do_reset();
      send(DATA_W'(32'h5), 1'b0);
      for (int i = 0; i < 20; i++) idle(1'b0);
      check("stall_sat", DATA_W'(stall_cnt), DATA_W'(CNT_MAX));
      idle(1'b0);
      check("stall_sat_hold", DATA_W'(stall_cnt), DATA_W'(CNT_MAX));
      flush = 1'b1;
      idle(1'b1);

      // Consumer ready toggling every cycle under continuous input.
      do_reset();
      for (int i = 0; i < 24; i++) send(DATA_W'(32'h100 + i), i[0]);
      idle(1'b1);
      idle(1'b1);

      // Randomised traffic with occasional flush and reset.
      for (int i = 0; i < 500; i++) begin
         rd = {$urandom(), $urandom(), $urandom(), $urandom()};
         step(($urandom_range(0, 3) != 0), rd, CTRL_W'($urandom()),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 63) == 0));
      end
      idle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
